// File: rtl/conv_pkg.sv
// Shared types and elaboration-time helpers for the transposed-convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int ofm_size(input int ifm, input int k, input int s, input int p);
    return (ifm - 1) * s - 2 * p + k;
  endfunction

  // Address/counter width, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/conv_requant.sv
// Combinational requantisation: round-half-up arithmetic shift, optional ReLU, saturate.
module conv_requant #(
  parameter int PSUM_WIDTH = 48,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 8,
  parameter int RELU       = 1
) (
  input  logic signed [PSUM_WIDTH-1:0] sum,
  output logic signed [OUT_WIDTH-1:0]  result
);

  // HALF is zero when SHIFT is zero, so the same expression covers both cases.
  localparam logic signed [PSUM_WIDTH-1:0] HALF =
    (SHIFT > 0) ? (PSUM_WIDTH'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [PSUM_WIDTH-1:0] OUT_MAX = (PSUM_WIDTH'(1) << (OUT_WIDTH - 1)) - 1;
  localparam logic signed [PSUM_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [PSUM_WIDTH-1:0] rounded;
  logic signed [PSUM_WIDTH-1:0] rect;

  always_comb begin
    rounded = (sum + HALF) >>> SHIFT;
    rect    = rounded;
    if (RELU != 0 && rounded < 0) rect = '0;
    if (rect > OUT_MAX)      result = OUT_MAX[OUT_WIDTH-1:0];
    else if (rect < OUT_MIN) result = OUT_MIN[OUT_WIDTH-1:0];
    else                     result = rect[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/conv_psum_accum.sv
// Cross-channel partial-sum accumulator with bias, requantisation and a
// valid/ready output register for the transposed-convolution engine.
module conv_psum_accum
  import conv_pkg::*;
#(
  parameter int PSUM_WIDTH  = 48,
  parameter int OUT_WIDTH   = 16,
  parameter int BIAS_WIDTH  = 32,
  parameter int IFM_SIZE    = 64,
  parameter int KERNEL_SIZE = 5,
  parameter int STRIDE      = 1,
  parameter int PAD         = 2,
  parameter int CI          = 3,
  parameter int CO          = 8,
  parameter int SHIFT       = 8,
  parameter int RELU        = 1,
  localparam int OFM_SIZE   = ofm_size(IFM_SIZE, KERNEL_SIZE, STRIDE, PAD),
  localparam int CO_W       = clog2_min1(CO)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [BIAS_WIDTH-1:0] bias_in,
  input  logic signed [PSUM_WIDTH-1:0] psum_in,
  input  logic                         psum_valid,
  output logic                         psum_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [CO_W-1:0]              out_co,
  output logic                         busy,
  output logic                         end_conv
);

  localparam int PIX   = OFM_SIZE * OFM_SIZE;
  localparam int PIX_W = clog2_min1(PIX);
  localparam int CI_W  = clog2_min1(CI);

  state_t state, state_nxt;
  logic [PIX_W-1:0] pix_cnt;
  logic [CI_W-1:0]  ci_cnt;
  logic [CO_W-1:0]  co_cnt;
  logic signed [PSUM_WIDTH-1:0] bias_sext;
  logic signed [PSUM_WIDTH-1:0] mem [PIX];

  logic accept, pix_last, ci_first, ci_last, co_last, chan_start;
  logic signed [PSUM_WIDTH-1:0] bias_cur, mem_rd, wr_data, sum;
  logic signed [OUT_WIDTH-1:0]  rq_data;

  assign pix_last   = (pix_cnt == PIX_W'(PIX - 1));
  assign ci_first   = (ci_cnt == '0);
  assign ci_last    = (ci_cnt == CI_W'(CI - 1));
  assign co_last    = (co_cnt == CO_W'(CO - 1));
  assign chan_start = (pix_cnt == '0) && ci_first;
  assign psum_ready = (state == RUN) && (!ci_last || !out_valid || out_ready);
  assign accept     = psum_valid && psum_ready;
  assign busy       = (state != IDLE);

  // The bias of a new output channel is live on its very first psum, before it is registered.
  assign bias_cur = chan_start ? PSUM_WIDTH'(bias_in) : bias_sext;
  assign mem_rd   = mem[pix_cnt];
  assign wr_data  = ci_first ? psum_in + bias_cur : mem_rd + psum_in;
  assign sum      = (CI == 1) ? psum_in + bias_cur : mem_rd + psum_in;

  conv_requant #(
    .PSUM_WIDTH(PSUM_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT),
    .RELU      (RELU)
  ) u_requant (
    .sum   (sum),
    .result(rq_data)
  );

  always_ff @(posedge clk) begin
    if (accept && !ci_last) mem[pix_cnt] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    end_conv  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (accept && pix_last && ci_last && co_last) state_nxt = DRAIN;
      DRAIN: begin
        if (!out_valid || out_ready) begin
          state_nxt = IDLE;
          end_conv  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt   <= '0;
      ci_cnt    <= '0;
      co_cnt    <= '0;
      bias_sext <= '0;
    end else if (state == IDLE && start) begin
      pix_cnt <= '0;
      ci_cnt  <= '0;
      co_cnt  <= '0;
    end else if (accept) begin
      if (chan_start) bias_sext <= PSUM_WIDTH'(bias_in);
      if (pix_last) begin
        pix_cnt <= '0;
        if (ci_last) begin
          ci_cnt <= '0;
          co_cnt <= co_last ? '0 : co_cnt + CO_W'(1);
        end else begin
          ci_cnt <= ci_cnt + CI_W'(1);
        end
      end else begin
        pix_cnt <= pix_cnt + PIX_W'(1);
      end
    end
  end

  // A load and a consumer accept in the same cycle simply overwrite, so there is no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_co    <= '0;
    end else if (accept && ci_last) begin
      out_data  <= rq_data;
      out_valid <= 1'b1;
      out_last  <= pix_last && co_last;
      out_co    <= co_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: doc/conv_psum_accum.md
Name: conv_psum_accum

Overview:
Parametrised cross-channel partial-sum accumulator and output stage for the transposed-convolution engine.
- Receives one PSUM_WIDTH partial sum per output pixel per input channel, in raster order from the PE-array/FIFO datapath.
- Accumulates over CI input channels in an internal OFM_SIZE×OFM_SIZE psum memory, then adds bias, rounds, shifts, applies optional ReLU and saturates.
- Emits OUT_WIDTH results on a valid/ready handshake for CO output channels.
- Replaces the fixed single-pass psum buffer and the hard-wired ReLU with per-channel bias, requantisation and backpressure.

Parameters:
- PSUM_WIDTH, 48, signed partial-sum and accumulator width.
- OUT_WIDTH, 16, signed output width.
- BIAS_WIDTH, 32, signed bias width; sign-extended to PSUM_WIDTH.
- IFM_SIZE, 64, input feature-map side.
- KERNEL_SIZE, 5, kernel side.
- STRIDE, 1, transposed-conv stride.
- PAD, 2, padding.
- OFM_SIZE, (IFM_SIZE-1)*STRIDE-2*PAD+KERNEL_SIZE, output side; derived, not overridden.
- CI, 3, input channels (≥1).
- CO, 8, output channels (≥1).
- SHIFT, 8, requantisation right shift (0..PSUM_WIDTH-1).
- RELU, 1, 1 = clamp negative results to 0.

Ports:
- clk, input, 1, single clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, layer start pulse; honoured only in IDLE.
- bias_in, input, BIAS_WIDTH, bias of the current output channel.
- psum_in, input, PSUM_WIDTH, partial sum.
- psum_valid, input, 1, psum_in valid.
- psum_ready, output, 1, psum_in accepted when psum_valid && psum_ready.
- out_data, output, OUT_WIDTH, requantised result.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, consumer accepts.
- out_last, output, 1, qualifies out_valid; last pixel of last output channel.
- out_co, output, clog2(CO) (min 1), output-channel index of out_data.
- busy, output, 1, state != IDLE.
- end_conv, output, 1, one-cycle pulse when the layer completes.

Behaviour:
- Reset: state IDLE; all counters 0; psum_ready, out_valid, out_last, busy, end_conv = 0; out_data and out_co = 0. Psum memory is not reset.
- FSM:
  - IDLE -> RUN on start; pix_cnt, ci_cnt, co_cnt cleared.
  - RUN -> DRAIN on acceptance of the psum with pix=OFM_SIZE²-1, ci=CI-1, co=CO-1.
  - DRAIN -> IDLE when the output register is empty or accepted this cycle; end_conv = 1 in that same cycle.
- Counters:
  - pix_cnt 0..OFM_SIZE²-1 increments per accepted psum.
  - On pix wrap, ci_cnt increments.
  - On ci wrap, co_cnt increments.
- bias_sext: captured on the accepted psum with pix=0, ci=0 and held for the whole output channel. It is used for that first psum, so bias_in must already be valid when that psum is offered.
- Accepted psum, by channel position:
  - ci=0 and CI>1: mem[pix] <= psum_in + bias_sext.
  - 0<ci<CI-1: mem[pix] <= mem[pix] + psum_in.
  - ci=CI-1: sum = (CI==1 ? psum_in + bias_sext : mem[pix] + psum_in); memory not written; sum goes to requant.
- All additions wrap modulo 2^PSUM_WIDTH.
- Requant (combinational, in order):
  1. If SHIFT>0, r = (sum + 2^(SHIFT-1)) >>> SHIFT (round half up, arithmetic); else r = sum.
  2. If RELU and r<0, r = 0.
  3. Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Output register: loaded at the acceptance edge of a last-channel psum, so out_valid rises the next cycle (latency 1). out_co = co_cnt at load; out_last set for the final pixel of co=CO-1. Holds value until out_ready.
- psum_ready = (state==RUN) && (ci_cnt!=CI-1 || !out_valid || out_ready).
  - Non-final channels never stall.
  - Final-channel psums stall while the output is blocked.
- Simultaneous output accept and new load: the register reloads with no bubble.
- start while busy: ignored.
- psum_valid in IDLE/DRAIN: ignored (ready = 0).
- rst_n low mid-layer: immediate abort to reset values; the next start runs a clean layer (ci=0 overwrite makes stale memory irrelevant).
- Memory: single read port (mem[pix_cnt]) and single write port, same cycle; no read/write hazard because each pixel address is touched once per channel pass.

Decomposition:
- conv_pkg:
  - function ofm_size(ifm, k, s, p).
  - clog2 helper.
  - state encoding constants IDLE/RUN/DRAIN.
- Sub-module conv_requant: purely combinational round/shift/ReLU/saturate, parameters PSUM_WIDTH, OUT_WIDTH, SHIFT, RELU; unit-tested on its own.
- Psum memory is inferred inside conv_psum_accum.

Test Plan:
All scenarios use IFM_SIZE=2, KERNEL_SIZE=3, STRIDE=1, PAD=1 (OFM=2, 4 pixels), CI=2, CO=2, OUT_WIDTH=8, SHIFT=0, RELU=1, out_ready=1 unless stated.
1. Basic: bias 10; ci0 psums 1,2,3,4; ci1 psums 5,6,7,8 -> out 16,18,20,22, out_co=0, each one cycle after its ci1 psum. Repeat with bias 0 for co=1 -> out_last only on the 4th output. end_conv pulses once after the 8th output.
2. ReLU/saturation: bias -100, psums 1 -> out 0. Bias 0, psums 200+100 -> 127. With RELU=0, sum -300 -> -128.
3. Rounding: SHIFT=2, RELU=0. Sums 6, 5, -6, -7 -> 2, 1, -1, -2.
4. Backpressure: out_ready=0 during ci1 -> first ci1 psum accepted, psum_ready drops, out_data held. Release -> remaining outputs in order, none lost or duplicated.
5. CI=1 path: bias 3, psums 1..4 -> outputs 4..7; memory never written.
6. Control: start during RUN ignored. rst_n pulsed low after 5 psums -> all outputs 0, state IDLE. Restart with scenario 1 stimulus -> identical results.
